// File: rtl/btn_cond_if.sv
// rtl/btn_cond_if.sv - button conditioner port bundle: raw buttons in, conditioned events out
interface btn_cond_if;
  logic [2:0] i_nBtn;
  logic [2:0] o_Level;
  logic [2:0] o_Press;
  logic [2:0] o_Release;
  logic [2:0] o_Long;

  modport master (
    output i_nBtn,
    input  o_Level,
    input  o_Press,
    input  o_Release,
    input  o_Long
  );

  modport slave (
    input  i_nBtn,
    output o_Level,
    output o_Press,
    output o_Release,
    output o_Long
  );
endinterface

// File: rtl/btn_cond.sv
// rtl/btn_cond.sv - three-channel push-button conditioner
// Synchronise, debounce, then derive press/release/long-press pulses per channel.
module btn_cond #(
  parameter int DEB_CNT  = 1_000_000,
  parameter int LONG_CNT = 100_000_000
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  btn_cond_if.slave   btn
);

  localparam int DW = $clog2(DEB_CNT);
  localparam int LW = $clog2(LONG_CNT);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CNT - 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CNT - 1);

  logic [2:0]    sync1_q, sync1_d;
  logic [2:0]    sync2_q, sync2_d;
  logic [2:0]    stable_q, stable_d;
  logic [2:0]    level_q, level_d;
  logic [2:0]    press_q, press_d;
  logic [2:0]    rel_q, rel_d;
  logic [2:0]    long_q, long_d;
  logic [2:0]    fired_q, fired_d;
  logic [DW-1:0] deb_q  [3];
  logic [DW-1:0] deb_d  [3];
  logic [LW-1:0] hold_q [3];
  logic [LW-1:0] hold_d [3];

  always_comb begin
    sync1_d  = btn.i_nBtn;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    fired_d  = fired_q;
    long_d   = '0;
    for (int c = 0; c < 3; c++) begin
      deb_d[c]  = '0;
      hold_d[c] = hold_q[c];
    end

    // A flip needs DEB_CNT consecutive disagreeing cycles; any agreement restarts the count.
    for (int c = 0; c < 3; c++) begin
      if (sync2_q[c] != stable_q[c]) begin
        if (deb_q[c] == DEB_LAST) begin
          stable_d[c] = sync2_q[c];
        end else begin
          deb_d[c] = deb_q[c] + 1'b1;
        end
      end
    end

    level_d = ~stable_d;
    press_d = level_d & ~level_q;
    rel_d   = ~level_d & level_q;

    // A long pulse landing on the release edge is dropped so it never coincides with o_Release.
    for (int c = 0; c < 3; c++) begin
      if (!level_q[c]) begin
        hold_d[c]  = '0;
        fired_d[c] = 1'b0;
      end else if (!fired_q[c]) begin
        if (hold_q[c] == LONG_LAST) begin
          fired_d[c] = 1'b1;
          long_d[c]  = level_d[c];
        end else begin
          hold_d[c] = hold_q[c] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      stable_q <= '1;
      level_q  <= '0;
      press_q  <= '0;
      rel_q    <= '0;
      long_q   <= '0;
      fired_q  <= '0;
      for (int c = 0; c < 3; c++) begin
        deb_q[c]  <= '0;
        hold_q[c] <= '0;
      end
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      level_q  <= level_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      long_q   <= long_d;
      fired_q  <= fired_d;
      for (int c = 0; c < 3; c++) begin
        deb_q[c]  <= deb_d[c];
        hold_q[c] <= hold_d[c];
      end
    end
  end

  assign btn.o_Level   = level_q;
  assign btn.o_Press   = press_q;
  assign btn.o_Release = rel_q;
  assign btn.o_Long    = long_q;

endmodule

// File: doc/btn_cond.md
BTN_COND -- requirements
Module: btn_cond

Interface
REQ-001 SHALL provide parameter DEB_CNT, default 1_000_000, debounce window in clock cycles (10 ms at 100 MHz); legal range >= 2.
REQ-002 SHALL provide parameter LONG_CNT, default 100_000_000, long-press threshold in clock cycles (1 s at 100 MHz); legal range >= 2.
REQ-003 SHALL have port i_Clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port i_Rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_nBtn  input  3  raw asynchronous push-buttons, active-low; bit0 start, bit1 stop, bit2 record.
REQ-006 SHALL have port o_Level  output  3  debounced button state, active-high (1 = held).
REQ-007 SHALL have port o_Press  output  3  one-cycle pulse per channel on debounced press.
REQ-008 SHALL have port o_Release  output  3  one-cycle pulse per channel on debounced release.
REQ-009 SHALL have port o_Long  output  3  one-cycle pulse per channel when a press has been held LONG_CNT cycles.

Function
REQ-010 SHALL implement three identical, fully independent channels; all rules below apply per channel.
REQ-011 SHALL pass each i_nBtn bit through a 2-flop synchronizer before any other logic; only the second-flop output (synced) is used.
REQ-012 SHALL keep a debounce counter of width clog2(DEB_CNT): cleared when synced equals the stable state, incremented by 1 each cycle when they differ.
REQ-013 SHALL flip the stable state, and clear the counter, at the edge where synced differs from stable and the counter equals DEB_CNT-1.
REQ-014 SHALL make any bounce shorter than DEB_CNT consecutive differing cycles invisible on all outputs (counter restarts from 0).
REQ-015 SHALL drive o_Level from a register equal to the inverted stable state.
REQ-016 SHALL register o_Press/o_Release so each rises at the same edge o_Level rises/falls and stays high exactly one cycle.
REQ-017 Latency: with edge 0 = first edge sampling raw low, o_Level and o_Press SHALL assert at edge DEB_CNT+1; release is symmetric.
REQ-018 SHALL keep a hold counter of width clog2(LONG_CNT) plus a fired flag: both cleared while o_Level=0; counter increments each cycle while o_Level=1 and fired=0.
REQ-019 SHALL pulse o_Long for one cycle and set fired at the edge where o_Level=1, fired=0 and the hold counter equals LONG_CNT-1, i.e. LONG_CNT edges after o_Level rose.
REQ-020 SHALL emit at most one o_Long per press (no auto-repeat); release before threshold SHALL produce no o_Long.
REQ-021 o_Long and o_Release SHALL never be high in the same cycle; o_Press and o_Release likewise.
REQ-022 Simultaneous activity on several channels SHALL produce the same per-channel timing as each channel alone.

Reset
REQ-023 On i_Rst low, immediately: synchronizer flops and stable state = 1 (released), all counters = 0, fired = 0, o_Level = o_Press = o_Release = o_Long = 3'b000.
REQ-024 Reset mid-operation SHALL abort any debounce or hold count without generating any pulse.
REQ-025 A button held low through reset release SHALL be treated as a new press: o_Press after the normal REQ-017 latency.

Verification (DEB_CNT=4, LONG_CNT=16)
REQ-026 Clean press: i_nBtn[0] 1->0 before edge 0, held -> o_Level[0]=1 and o_Press[0]=1 at edge 5, o_Press[0]=0 at edge 6; other bits stay 0.
REQ-027 Bounce: i_nBtn[1] low 3 cycles, high 2, low held -> no pulse during bounce; o_Press[1] exactly once, 5 edges after the final low is first sampled.
REQ-028 Long press: hold i_nBtn[2] low -> o_Press[2] at edge E, o_Long[2] single pulse at E+16, none afterwards while held; on release o_Release[2] once, no o_Long.
REQ-029 Short press: press held 10 cycles after o_Level rises, then release -> o_Press and o_Release once each, o_Long never.
REQ-030 Reset mid-count: assert i_Rst at o_Level-rise+8 while held, release reset with button still low -> all outputs 0 during reset; new o_Press 6 edges after reset release (sync + debounce), o_Long 16 edges later.
REQ-031 Concurrency: press bits 0 and 2 on the same edge, release bit 0 after 20 cycles -> identical press timing on both, o_Long on each at E+16, o_Release[0] only.
